// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_writer
// Serialises one PE result tile per handshake into an output BRAM, element 0 first.
// Revision : 1.0
// ============================================================================
module conv_result_writer #(
    parameter int NUM_ELEMS  = 4,
    parameter int ELEM_WIDTH = 20,
    parameter int DOUT_WIDTH = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 32768,
    parameter int SATURATE   = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            bram_en,
    output logic                            bram_we,
    output logic [ADDR_WIDTH-1:0]           bram_addr,
    output logic [DOUT_WIDTH-1:0]           bram_din,
    output logic                            done,
    output logic                            sat_flag,
    output logic [15:0]                     tile_count
);

    localparam int c_IDX_W = $clog2(NUM_ELEMS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [NUM_ELEMS*ELEM_WIDTH-1:0] r_data;
    logic [NUM_ELEMS*ELEM_WIDTH-1:0] w_data_nxt;
    logic [c_IDX_W-1:0]              r_idx;
    logic [c_IDX_W-1:0]              w_idx_nxt;
    logic [ADDR_WIDTH-1:0]           r_ptr;
    logic [ADDR_WIDTH-1:0]           w_ptr_nxt;
    logic [ADDR_WIDTH-1:0]           w_ptr_inc;

    logic                            r_in_ready;
    logic                            w_in_ready_nxt;
    logic                            r_we;
    logic                            w_we_nxt;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [ADDR_WIDTH-1:0]           w_addr_nxt;
    logic [DOUT_WIDTH-1:0]           r_din;
    logic [DOUT_WIDTH-1:0]           w_din_nxt;
    logic                            r_done;
    logic                            w_done_nxt;
    logic                            r_sat;
    logic                            w_sat_nxt;
    logic [15:0]                     r_tiles;
    logic [15:0]                     w_tiles_nxt;

    logic [NUM_ELEMS*ELEM_WIDTH-1:0] w_src;
    logic [ELEM_WIDTH-1:0]           w_elems [NUM_ELEMS];
    logic [c_IDX_W-1:0]              w_sel_idx;
    logic [ELEM_WIDTH-1:0]           w_elem;
    logic [DOUT_WIDTH-1:0]           w_conv;
    logic                            w_clamp;

    // Element 0 is written on the handshake edge straight from the input bus.
    assign w_src     = (r_state == S_IDLE) ? in_data : r_data;
    assign w_sel_idx = (r_state == S_IDLE) ? '0 : r_idx;

    for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_unpack
        assign w_elems[k] = w_src[(NUM_ELEMS-1-k)*ELEM_WIDTH +: ELEM_WIDTH];
    end

    always_comb begin
        w_elem = w_elems[0];
        for (int k = 0; k < NUM_ELEMS; k++) begin
            if (w_sel_idx == c_IDX_W'(k)) begin
                w_elem = w_elems[k];
            end
        end
    end

    if (ELEM_WIDTH > DOUT_WIDTH) begin : g_narrow
        logic [ELEM_WIDTH-DOUT_WIDTH:0] w_upper;
        logic                           w_in_range;

        // In range when every bit above the output sign bit repeats it.
        assign w_upper    = w_elem[ELEM_WIDTH-1:DOUT_WIDTH-1];
        assign w_in_range = (&w_upper) | ~(|w_upper);

        if (SATURATE != 0) begin : g_sat
            assign w_conv  = w_in_range ? w_elem[DOUT_WIDTH-1:0]
                           : (w_elem[ELEM_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(DOUT_WIDTH-1){1'b1}}});
            assign w_clamp = ~w_in_range;
        end else begin : g_wrap
            assign w_conv  = w_elem[DOUT_WIDTH-1:0];
            assign w_clamp = 1'b0;
        end
    end else begin : g_extend
        assign w_conv  = DOUT_WIDTH'($signed(w_elem));
        assign w_clamp = 1'b0;
    end

    assign w_ptr_inc = (r_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_ptr + ADDR_WIDTH'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_idx_nxt      = r_idx;
        w_ptr_nxt      = r_ptr;
        w_in_ready_nxt = r_in_ready;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_din_nxt      = r_din;
        w_done_nxt     = 1'b0;
        w_sat_nxt      = r_sat;
        w_tiles_nxt    = r_tiles;

        case (r_state)
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                if (in_valid && r_in_ready) begin
                    w_data_nxt     = in_data;
                    w_idx_nxt      = c_IDX_W'(1);
                    w_in_ready_nxt = 1'b0;
                    w_we_nxt       = 1'b1;
                    w_addr_nxt     = r_ptr;
                    w_din_nxt      = w_conv;
                    w_ptr_nxt      = w_ptr_inc;
                    w_sat_nxt      = r_sat | w_clamp;
                    w_state_nxt    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_idx == c_IDX_W'(NUM_ELEMS)) begin
                    w_done_nxt  = 1'b1;
                    w_tiles_nxt = r_tiles + 16'd1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_we_nxt   = 1'b1;
                    w_addr_nxt = r_ptr;
                    w_din_nxt  = w_conv;
                    w_ptr_nxt  = w_ptr_inc;
                    w_sat_nxt  = r_sat | w_clamp;
                    w_idx_nxt  = r_idx + c_IDX_W'(1);
                end
            end
            S_DONE: begin
                w_in_ready_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
            default: begin
                w_in_ready_nxt = 1'b1;
                w_state_nxt    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
            r_tiles    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_idx      <= w_idx_nxt;
            r_ptr      <= w_ptr_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_din      <= w_din_nxt;
            r_done     <= w_done_nxt;
            r_sat      <= w_sat_nxt;
            r_tiles    <= w_tiles_nxt;
        end
    end

    assign in_ready   = r_in_ready;
    assign bram_en    = r_we;
    assign bram_we    = r_we;
    assign bram_addr  = r_addr;
    assign bram_din   = r_din;
    assign done       = r_done;
    assign sat_flag   = r_sat;
    assign tile_count = r_tiles;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_writer
// Scoreboard bench driving three writer configurations with a shared stimulus.
// Revision : 1.0
// ============================================================================
module tb_conv_result_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic [79:0] in_data;
    logic        in_valid;

    logic        rdy0, en0, we0, done0, sat0;
    logic [14:0] addr0;
    logic [7:0]  din0;
    logic [15:0] tc0;
    logic        rdy1, en1, we1, done1, sat1;
    logic [14:0] addr1;
    logic [7:0]  din1;
    logic [15:0] tc1;
    logic        rdy2, en2, we2, done2, sat2;
    logic [14:0] addr2;
    logic [7:0]  din2;
    logic [15:0] tc2;

    int n_checks = 0;
    int n_errors = 0;

    logic [22:0] q0[$];
    logic [22:0] q1[$];
    logic [22:0] q2[$];
    int          p0, p1, p2;
    bit          exp_sat0, exp_sat1;
    int          exp_tiles;
    bit          prev_we0, prev_we1, prev_we2;
    logic [22:0] ent0, ent1, ent2;

    always #5 clk = ~clk;

    conv_result_writer u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .bram_en(en0), .bram_we(we0), .bram_addr(addr0),
        .bram_din(din0), .done(done0), .sat_flag(sat0), .tile_count(tc0));

    conv_result_writer #(.DEPTH(6)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .bram_en(en1), .bram_we(we1), .bram_addr(addr1),
        .bram_din(din1), .done(done1), .sat_flag(sat1), .tile_count(tc1));

    conv_result_writer #(.SATURATE(0)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy2), .bram_en(en2), .bram_we(we2), .bram_addr(addr2),
        .bram_din(din2), .done(done2), .sat_flag(sat2), .tile_count(tc2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] conv(input logic [19:0] e, input bit sat);
        int v;
        v = $signed(e);
        if (sat && v > 127)  return 8'h7F;
        if (sat && v < -128) return 8'h80;
        return e[7:0];
    endfunction

    function automatic bit clamps(input logic [19:0] e);
        int v;
        v = $signed(e);
        return (v > 127) || (v < -128);
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        p0 = 0; p1 = 0; p2 = 0;
        exp_sat0 = 0; exp_sat1 = 0; exp_tiles = 0;
    endtask

    task automatic accept(input logic [79:0] d);
        logic [19:0] e;
        for (int k = 0; k < 4; k++) begin
            e = d[(3-k)*20 +: 20];
            q0.push_back({15'(p0), conv(e, 1'b1)});
            q1.push_back({15'(p1), conv(e, 1'b1)});
            q2.push_back({15'(p2), conv(e, 1'b0)});
            p0 = (p0 + 1) % 32768;
            p1 = (p1 + 1) % 6;
            p2 = (p2 + 1) % 32768;
            if (clamps(e)) begin
                exp_sat0 = 1;
                exp_sat1 = 1;
            end
        end
        exp_tiles++;
    endtask

    // Returns #1 after the handshake edge; in_valid is left asserted.
    task automatic send_tile(input logic [79:0] d);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!rdy0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy0) chk("ready_timeout", 0, 1);
        @(posedge clk);
        accept(d);
        #1;
    endtask

    task automatic check_timing(input string tag);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk({tag, "_we"},    we0,   (c <= 4) ? 1 : 0);
            chk({tag, "_done"},  done0, (c == 5) ? 1 : 0);
            chk({tag, "_ready"}, rdy0,  (c == 6) ? 1 : 0);
        end
    endtask

    function automatic logic [79:0] rand_tile();
        logic [79:0] d;
        logic [7:0]  s;
        for (int k = 0; k < 4; k++) begin
            s = 8'($urandom);
            d[k*20 +: 20] = ($urandom_range(0, 1) == 1) ? 20'($urandom) : {{12{s[7]}}, s};
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (we0) begin
            if (q0.size() == 0) chk("wr0_unexpected", 1, 0);
            else begin
                ent0 = q0.pop_front();
                chk("wr0_addr", addr0, ent0[22:8]);
                chk("wr0_din",  din0,  ent0[7:0]);
            end
        end
        if (done0) chk("done0_after_write", prev_we0, 1);
        prev_we0 = we0;
    end

    always @(negedge clk) begin
        if (we1) begin
            if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
            else begin
                ent1 = q1.pop_front();
                chk("wr1_addr", addr1, ent1[22:8]);
                chk("wr1_din",  din1,  ent1[7:0]);
            end
        end
        if (done1) chk("done1_after_write", prev_we1, 1);
        prev_we1 = we1;
    end

    always @(negedge clk) begin
        if (we2) begin
            if (q2.size() == 0) chk("wr2_unexpected", 1, 0);
            else begin
                ent2 = q2.pop_front();
                chk("wr2_addr", addr2, ent2[22:8]);
                chk("wr2_din",  din2,  ent2[7:0]);
            end
        end
        if (done2) chk("done2_after_write", prev_we2, 1);
        prev_we2 = we2;
    end

    initial begin
        model_reset();
        // in_valid held during reset must not start a tile.
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 80'h00005_FFFFF_00200_FFE00;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_ready", rdy0, 1);
            chk("idle_we",    we0,  0);
            chk("idle_en",    en0,  0);
            chk("idle_done",  done0, 0);
            chk("idle_tiles", tc0,  0);
            chk("idle_sat",   sat0, 0);
        end

        // Tile A, then tile B with in_valid held high throughout.
        send_tile(80'h00005_FFFFF_00200_FFE00);
        in_data = 80'h00001_00002_00003_00312;
        check_timing("tileA");
        chk("A_tiles0", tc0, 1);
        chk("A_tiles1", tc1, 1);
        chk("A_sat0",   sat0, 1);
        chk("A_sat2",   sat2, 0);

        send_tile(80'h00001_00002_00003_00312);
        in_valid = 1'b0;
        check_timing("tileB");
        chk("B_tiles0", tc0, 2);
        chk("B_tiles1", tc1, 2);
        chk("B_tiles2", tc2, 2);

        // Clamp boundaries: 127, -128, 128, -129.
        send_tile(80'h0007F_FFF80_00080_FFF7F);
        in_valid = 1'b0;
        check_timing("tileC");
        chk("C_sat0", sat0, exp_sat0);
        chk("C_sat1", sat1, exp_sat1);
        chk("C_sat2", sat2, 0);

        // Reset on the second write cycle.
        send_tile(80'h12345_00001_FFFFE_00050);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_we",    we0,   0);
        chk("rst_ready", rdy0,  1);
        chk("rst_done",  done0, 0);
        chk("rst_tiles", tc0,   0);
        chk("rst_sat",   sat0,  0);
        @(negedge clk);
        chk("rst_done2", done0, 0);
        chk("rst_we2",   we0,   0);

        send_tile(80'h00010_00020_00030_00040);
        in_valid = 1'b0;
        check_timing("tileE");
        chk("E_tiles0", tc0, 1);
        chk("E_tiles1", tc1, 1);

        for (int t = 0; t < 6; t++) begin
            send_tile(rand_tile());
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        chk("end_q0", q0.size(), 0);
        chk("end_q1", q1.size(), 0);
        chk("end_q2", q2.size(), 0);
        chk("end_tiles0", tc0, exp_tiles);
        chk("end_tiles1", tc1, exp_tiles);
        chk("end_tiles2", tc2, exp_tiles);
        chk("end_sat0", sat0, exp_sat0);
        chk("end_sat1", sat1, exp_sat1);
        chk("end_sat2", sat2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
